// File: rtl/panel_switch_conditioner.sv
// Synchronises, debounces and classifies active-low panel buttons (short/long press).
// Pulses are registered, one CLK after the causing sample tick; no backpressure, events are never held.
module panel_switch_conditioner #(
  parameter int NBUT     = 2,
  parameter int TICK_DIV = 1024,
  parameter int DEB_CNT  = 8,
  parameter int LONG_CNT = 256
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [NBUT-1:0] nBUT,
  output logic            tick,
  output logic [NBUT-1:0] level,
  output logic [NBUT-1:0] press,
  output logic [NBUT-1:0] release_pulse,
  output logic [NBUT-1:0] long_press,
  output logic [NBUT-1:0] short_press
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CNT + 1);
  localparam int HW = $clog2(LONG_CNT + 1);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEB_CNT - 1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CNT - 1);

  typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

  logic [PW-1:0]   pre;
  logic [NBUT-1:0] sync1, sync2;
  logic [NBUT-1:0] s;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pre <= '0;
    end else if (pre == P_LAST) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  assign tick = (pre == P_LAST);

  // Sync chain carries the raw active-low value, so reset to 1 means "released".
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= nBUT;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  for (genvar i = 0; i < NBUT; i++) begin : g_but
    logic [DW-1:0] dcnt, dcnt_nxt;
    logic [HW-1:0] hcnt, hcnt_nxt;
    logic          lvl_q, lvl_nxt;
    state_t        state, state_nxt;
    logic          pr_q, rl_q, lg_q, sh_q;
    logic          pr_nxt, rl_nxt, lg_nxt, sh_nxt;

    always_comb begin
      dcnt_nxt = dcnt;
      lvl_nxt  = lvl_q;
      if (tick) begin
        if (s[i] == lvl_q) begin
          dcnt_nxt = '0;
        end else if (dcnt == D_LAST) begin
          dcnt_nxt = '0;
          lvl_nxt  = ~lvl_q;
        end else begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end
    end

    // A fall on the same tick that would complete the long count wins: it is a short press.
    always_comb begin
      state_nxt = state;
      hcnt_nxt  = hcnt;
      pr_nxt    = 1'b0;
      rl_nxt    = 1'b0;
      lg_nxt    = 1'b0;
      sh_nxt    = 1'b0;
      unique case (state)
        IDLE: begin
          if (lvl_nxt && !lvl_q) begin
            state_nxt = HELD;
            pr_nxt    = 1'b1;
          end
        end
        HELD: begin
          if (!lvl_nxt && lvl_q) begin
            state_nxt = IDLE;
            hcnt_nxt  = '0;
            rl_nxt    = 1'b1;
            sh_nxt    = 1'b1;
          end else if (tick && lvl_q) begin
            if (hcnt == H_LAST) begin
              state_nxt = LONG;
              lg_nxt    = 1'b1;
            end else begin
              hcnt_nxt = hcnt + 1'b1;
            end
          end
        end
        LONG: begin
          if (!lvl_nxt && lvl_q) begin
            state_nxt = IDLE;
            hcnt_nxt  = '0;
            rl_nxt    = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          hcnt_nxt  = '0;
        end
      endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        dcnt  <= '0;
        hcnt  <= '0;
        lvl_q <= 1'b0;
        state <= IDLE;
        pr_q  <= 1'b0;
        rl_q  <= 1'b0;
        lg_q  <= 1'b0;
        sh_q  <= 1'b0;
      end else begin
        dcnt  <= dcnt_nxt;
        hcnt  <= hcnt_nxt;
        lvl_q <= lvl_nxt;
        state <= state_nxt;
        pr_q  <= pr_nxt;
        rl_q  <= rl_nxt;
        lg_q  <= lg_nxt;
        sh_q  <= sh_nxt;
      end
    end

    assign level[i]         = lvl_q;
    assign press[i]         = pr_q;
    assign release_pulse[i] = rl_q;
    assign long_press[i]    = lg_q;
    assign short_press[i]   = sh_q;
  end

endmodule

// File: tb/tb_panel_switch_conditioner.sv
// Directed bench for panel_switch_conditioner with a pulse scoreboard and timed checkpoints.
module tb_panel_switch_conditioner;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b1;
  logic [1:0] nBUT  = 2'b11;
  logic       tick;
  logic [1:0] level, press, release_pulse, long_press, short_press;

  logic nbut2 = 1'b1;
  logic tick2, level2, press2, release2, long2, short2;

  always #5 CLK = ~CLK;

  panel_switch_conditioner #(.NBUT(2), .TICK_DIV(4), .DEB_CNT(3), .LONG_CNT(5)) dut (
    .CLK(CLK), .RESET(RESET), .nBUT(nBUT), .tick(tick), .level(level), .press(press),
    .release_pulse(release_pulse), .long_press(long_press), .short_press(short_press)
  );

  panel_switch_conditioner #(.NBUT(1), .TICK_DIV(2), .DEB_CNT(1), .LONG_CNT(2)) dut_edge (
    .CLK(CLK), .RESET(RESET), .nBUT(nbut2), .tick(tick2), .level(level2), .press(press2),
    .release_pulse(release2), .long_press(long2), .short_press(short2)
  );

  typedef struct {
    int         at;
    logic [1:0] pr;
    logic [1:0] rl;
    logic [1:0] lg;
    logic [1:0] sh;
    string      nm;
  } ev_t;

  typedef struct {
    int         at;
    int         sel;
    logic [7:0] val;
    string      nm;
  } chk_t;

  ev_t        ev_q[$];
  chk_t       chk_q[$];
  ev_t        e;
  chk_t       c;
  logic [7:0] got;
  int gcyc = 0;
  int rel  = 0;
  int nvec = 0;
  int nmis = 0;

  always @(posedge CLK) gcyc <= gcyc + 1;

  // Monitor: pulse events are matched in order; checkpoints are sampled at their cycle.
  always @(negedge CLK) begin
    if (!RESET && ((press | release_pulse | long_press | short_press) != 2'b00)) begin
      nvec++;
      if (ev_q.size() == 0) begin
        nmis++;
        $display("FAIL unexpected_pulse: cycle %0d got press=%b release=%b long=%b short=%b, required no pulse",
                 gcyc - rel, press, release_pulse, long_press, short_press);
      end else begin
        e = ev_q.pop_front();
        if (e.at != gcyc - rel || e.pr != press || e.rl != release_pulse ||
            e.lg != long_press || e.sh != short_press) begin
          nmis++;
          $display("FAIL %s: got cycle %0d press=%b release=%b long=%b short=%b, required cycle %0d press=%b release=%b long=%b short=%b",
                   e.nm, gcyc - rel, press, release_pulse, long_press, short_press,
                   e.at, e.pr, e.rl, e.lg, e.sh);
        end
      end
    end
    while (chk_q.size() > 0 && chk_q[0].at <= gcyc) begin
      c = chk_q.pop_front();
      case (c.sel)
        0: got = {6'b0, level};
        1: got = {7'b0, tick | (|level) | (|press) | (|release_pulse) | (|long_press) | (|short_press)};
        2: got = {7'b0, tick2};
        3: got = {7'b0, level2};
        4: got = {4'b0, press2, release2, long2, short2};
        default: got = 8'(ev_q.size());
      endcase
      nvec++;
      if (c.at != gcyc || got != c.val) begin
        nmis++;
        $display("FAIL %s: got 0x%0h at abs cycle %0d, required 0x%0h at abs cycle %0d",
                 c.nm, got, gcyc, c.val, c.at);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_to(input int k);
    while (gcyc - rel < k) step();
  endtask

  task automatic ev(input int k, input logic [1:0] pr, input logic [1:0] rl,
                    input logic [1:0] lg, input logic [1:0] sh, input string nm);
    ev_q.push_back('{k, pr, rl, lg, sh, nm});
  endtask

  task automatic chk(input int k, input int sel, input logic [7:0] val, input string nm);
    chk_q.push_back('{rel + k, sel, val, nm});
  endtask

  task automatic do_reset(input logic [1:0] nb);
    step();
    RESET = 1'b1;
    nBUT  = nb;
    nbut2 = 1'b1;
    chk_q.push_back('{gcyc, 1, 8'd0, "outputs_in_reset"});
    chk_q.push_back('{gcyc, 5, 8'd0, "no_pending_events"});
    repeat (3) step();
    RESET = 1'b0;
    rel   = gcyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    // Buttons held through reset release: normal press after 3 ticks.
    do_reset(2'b00);
    chk(11, 0, 8'd0, "p1_level_before");
    chk(12, 0, 8'd3, "p1_level_after");
    ev(12, 2'b11, 2'b00, 2'b00, 2'b00, "p1_press");
    ev(32, 2'b00, 2'b00, 2'b11, 2'b00, "p1_long");
    ev(44, 2'b00, 2'b11, 2'b00, 2'b00, "p1_release");
    wait_to(33); nBUT = 2'b11;
    wait_to(50);

    // Clean long press on button 0.
    do_reset(2'b11);
    ev(16, 2'b01, 2'b00, 2'b00, 2'b00, "p2_press");
    ev(36, 2'b00, 2'b00, 2'b01, 2'b00, "p2_long");
    ev(64, 2'b00, 2'b01, 2'b00, 2'b00, "p2_release");
    wait_to(2);  nBUT[0] = 1'b0;
    wait_to(50); nBUT[0] = 1'b1;
    wait_to(70);

    // Bounce: toggling every 4 CLK never gives 3 equal samples.
    do_reset(2'b11);
    chk(20, 0, 8'd0, "p3_level_bounce_20");
    chk(30, 0, 8'd0, "p3_level_bounce_30");
    chk(40, 0, 8'd0, "p3_level_bounce_40");
    chk(50, 0, 8'd0, "p3_level_hold_50");
    chk(55, 0, 8'd0, "p3_level_hold_55");
    chk(56, 0, 8'd1, "p3_level_hold_56");
    ev(56, 2'b01, 2'b00, 2'b00, 2'b00, "p3_press");
    ev(72, 2'b00, 2'b01, 2'b00, 2'b01, "p3_short");
    for (int i = 0; i < 10; i++) begin
      wait_to(2 + 4 * i);
      nBUT[0] = (i % 2 == 1);
    end
    wait_to(42); nBUT[0] = 1'b0;
    wait_to(60); nBUT[0] = 1'b1;
    wait_to(80);

    // Short press on button 1: fall coincides with the would-be long tick.
    do_reset(2'b11);
    ev(16, 2'b10, 2'b00, 2'b00, 2'b00, "p4_press");
    ev(36, 2'b00, 2'b10, 2'b00, 2'b10, "p4_short");
    wait_to(2);  nBUT[1] = 1'b0;
    wait_to(22); nBUT[1] = 1'b1;
    wait_to(45);

    // Async reset while both buttons are in LONG.
    do_reset(2'b11);
    ev(16, 2'b11, 2'b00, 2'b00, 2'b00, "p5_press");
    ev(36, 2'b00, 2'b00, 2'b11, 2'b00, "p5_long");
    chk(39, 0, 8'd3, "p5_level_long");
    wait_to(2);  nBUT = 2'b00;
    wait_to(40);
    RESET = 1'b1;
    chk(40, 0, 8'd0, "p5_level_in_reset");
    chk(40, 1, 8'd0, "p5_outputs_in_reset");
    chk(40, 5, 8'd0, "p5_no_pending");
    step(); step();
    RESET = 1'b0;
    rel   = gcyc;
    ev(12, 2'b11, 2'b00, 2'b00, 2'b00, "p5_press_after_reset");
    wait_to(30);

    // Edge parameters on the second instance.
    do_reset(2'b11);
    for (int k = 0; k < 4; k++) chk(k, 2, 8'(k % 2), "p6_tick2_early");
    chk(5,  3, 8'd0,     "p6_level2_before");
    chk(6,  3, 8'd1,     "p6_level2_rise");
    chk(6,  4, 8'b1000,  "p6_press2");
    chk(10, 4, 8'b0010,  "p6_long2");
    chk(11, 3, 8'd1,     "p6_level2_held");
    chk(12, 3, 8'd0,     "p6_level2_fall");
    chk(12, 4, 8'b0100,  "p6_release2");
    for (int k = 13; k < 17; k++) chk(k, 2, 8'(k % 2), "p6_tick2_late");
    wait_to(2); nbut2 = 1'b0;
    wait_to(8); nbut2 = 1'b1;
    wait_to(20);

    chk(gcyc - rel + 1, 5, 8'd0, "final_no_pending");
    step(); step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
